// File: rtl/magnitude_comparator_tree.sv
// Unsigned magnitude comparator built as a SPLIT-ary reduction tree.
// Strict a>b / b>a flags are registered; equality shows as both flags low.
module magnitude_comparator_tree #(
   parameter int WIDTH = 4,
   parameter int SPLIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_a,
   output logic             o_b
);

   function automatic int calc_levels(input int w, input int s);
      int lv;
      int p;
      lv = 1;
      p  = s;
      while (p < w) begin
         p  = p * s;
         lv = lv + 1;
      end
      return lv;
   endfunction

   function automatic int calc_pow(input int s, input int e);
      int p;
      p = 1;
      for (int i = 0; i < e; i++) p = p * s;
      return p;
   endfunction

   localparam int LEVELS = calc_levels(WIDTH, SPLIT);
   localparam int PAD    = calc_pow(SPLIT, LEVELS);

   generate
      if (WIDTH < 1 || SPLIT < 2) begin : g_bad_params
         $error("magnitude_comparator_tree: WIDTH must be >= 1 and SPLIT >= 2");
      end
   endgenerate

   logic [PAD-1:0] a_pad;
   logic [PAD-1:0] b_pad;
   logic           gt_l [0:LEVELS][0:PAD-1];
   logic           lt_l [0:LEVELS][0:PAD-1];
   logic           o_a_d, o_a_q;
   logic           o_b_d, o_b_q;

   always_comb begin
      a_pad             = '0;
      b_pad             = '0;
      a_pad[WIDTH-1:0]  = i_a;
      b_pad[WIDTH-1:0]  = i_b;
      for (int l = 0; l <= LEVELS; l++) begin
         for (int k = 0; k < PAD; k++) begin
            gt_l[l][k] = 1'b0;
            lt_l[l][k] = 1'b0;
         end
      end

      for (int k = 0; k < PAD; k++) begin
         gt_l[0][k] = a_pad[k] & ~b_pad[k];
         lt_l[0][k] = ~a_pad[k] & b_pad[k];
      end

      // Each node takes the verdict of its most-significant undecided-free child.
      for (int l = 1; l <= LEVELS; l++) begin
         for (int n = 0; n < PAD; n++) begin
            if (n < PAD / calc_pow(SPLIT, l)) begin
               logic decided;
               decided = 1'b0;
               for (int j = SPLIT - 1; j >= 0; j--) begin
                  gt_l[l][n] = gt_l[l][n] | (gt_l[l-1][n*SPLIT+j] & ~decided);
                  lt_l[l][n] = lt_l[l][n] | (lt_l[l-1][n*SPLIT+j] & ~decided);
                  decided    = decided | gt_l[l-1][n*SPLIT+j] | lt_l[l-1][n*SPLIT+j];
               end
            end
         end
      end

      o_a_d = gt_l[LEVELS][0];
      o_b_d = lt_l[LEVELS][0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_a_q <= 1'b0;
         o_b_q <= 1'b0;
      end else begin
         o_a_q <= o_a_d;
         o_b_q <= o_b_d;
      end
   end

   assign o_a = o_a_q;
   assign o_b = o_b_q;

endmodule

// File: tb/tb_magnitude_comparator_tree.sv
// Bench for magnitude_comparator_tree: four instances (W4 with SPLIT 2/3/4, W7 SPLIT 2)
// checked every cycle against an arithmetic model, plus literal directed checks.
module tb_magnitude_comparator_tree;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] a4  = 4'hF;
   logic [3:0] b4  = 4'h0;
   logic [6:0] a7  = 7'h00;
   logic [6:0] b7  = 7'h00;

   logic oa_s2, ob_s2, oa_s3, ob_s3, oa_s4, ob_s4, oa_w7, ob_w7;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [1:0] exp4   = 2'b00;
   logic [1:0] exp7   = 2'b00;
   logic       mvalid = 1'b0;

   always #5 clk = ~clk;

   magnitude_comparator_tree #(.WIDTH(4), .SPLIT(2)) u_s2 (
      .clk(clk), .rst(rst), .i_a(a4), .i_b(b4), .o_a(oa_s2), .o_b(ob_s2));
   magnitude_comparator_tree #(.WIDTH(4), .SPLIT(3)) u_s3 (
      .clk(clk), .rst(rst), .i_a(a4), .i_b(b4), .o_a(oa_s3), .o_b(ob_s3));
   magnitude_comparator_tree #(.WIDTH(4), .SPLIT(4)) u_s4 (
      .clk(clk), .rst(rst), .i_a(a4), .i_b(b4), .o_a(oa_s4), .o_b(ob_s4));
   magnitude_comparator_tree #(.WIDTH(7), .SPLIT(2)) u_w7 (
      .clk(clk), .rst(rst), .i_a(a7), .i_b(b7), .o_a(oa_w7), .o_b(ob_w7));

   task automatic check(input string name, input logic [1:0] act, input logic [1:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got {o_a,o_b}=%b expected %b at %0t", name, act, expv, $time);
      end
   endtask

   // Reference: outputs equal (a>b, b>a) of the inputs seen at the previous edge, or 0 in reset.
   always @(posedge clk) begin
      exp4   <= rst ? 2'b00 : {a4 > b4, b4 > a4};
      exp7   <= rst ? 2'b00 : {a7 > b7, b7 > a7};
      mvalid <= 1'b1;
   end

   always @(negedge clk) begin
      if (mvalid) begin
         check("stream_s2", {oa_s2, ob_s2}, exp4);
         check("stream_s3", {oa_s3, ob_s3}, exp4);
         check("stream_s4", {oa_s4, ob_s4}, exp4);
         check("stream_w7", {oa_w7, ob_w7}, exp7);
      end
   end

   task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic r);
      @(negedge clk);
      a4  = a;
      b4  = b;
      rst = r;
      a7  = 7'($urandom_range(0, 127));
      b7  = ($urandom_range(0, 3) == 0) ? a7 : 7'($urandom_range(0, 127));
   endtask

   task automatic directed(input string name, input logic [3:0] a, input logic [3:0] b,
                           input logic r, input logic [1:0] expv);
      apply(a, b, r);
      @(posedge clk);
      #1;
      check({name, "_s2"}, {oa_s2, ob_s2}, expv);
      check({name, "_s3"}, {oa_s3, ob_s3}, expv);
      check({name, "_s4"}, {oa_s4, ob_s4}, expv);
   endtask

   initial begin
      @(posedge clk);
      #1;
      check("reset_s2", {oa_s2, ob_s2}, 2'b00);
      check("reset_s3", {oa_s3, ob_s3}, 2'b00);
      check("reset_s4", {oa_s4, ob_s4}, 2'b00);

      directed("zero",     4'h0,    4'h0,    1'b0, 2'b00);
      directed("a_gt_b",   4'd5,    4'd3,    1'b0, 2'b10);
      directed("b_gt_a",   4'd3,    4'd5,    1'b0, 2'b01);
      directed("msb_dom",  4'b1000, 4'b0111, 1'b0, 2'b10);
      directed("eq_f",     4'hF,    4'hF,    1'b0, 2'b00);
      directed("rst_mid",  4'd9,    4'd2,    1'b1, 2'b00);
      directed("resume",   4'd9,    4'd2,    1'b0, 2'b10);
      directed("lsb_only", 4'd6,    4'd7,    1'b0, 2'b01);

      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            apply(4'(a), 4'(b), 1'b0);

      for (int i = 0; i < 400; i++)
         apply(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               ($urandom_range(0, 19) == 0));

      apply(4'h0, 4'h0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
